// File: rtl/memory_stage.sv
// Y86-64 memory stage: E->M pipeline register plus an internal byte-addressed
// data RAM serving rmmovq, mrmovq, pushq, popq, call and ret. Loads are
// asynchronous, stores commit on the clock edge, 8 bytes little-endian with
// arbitrary byte alignment.
module memory_stage #(
    parameter int MEM_BYTES = 4096
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        memory_stall_i,
    input  logic        memory_bubble_i,
    input  logic [3:0]  e_icode_i,
    input  logic [2:0]  e_stat_i,
    input  logic [63:0] e_valE_i,
    input  logic [63:0] e_valA_i,
    input  logic [3:0]  e_dstE_i,
    input  logic [3:0]  e_dstM_i,
    input  logic        e_cnd_i,
    input  logic [2:0]  W_stat_i,
    output logic [3:0]  M_icode_o,
    output logic [63:0] M_valE_o,
    output logic [63:0] M_valA_o,
    output logic [3:0]  M_dstE_o,
    output logic [3:0]  M_dstM_o,
    output logic        M_cnd_o,
    output logic [63:0] m_valM_o,
    output logic [2:0]  m_stat_o
);

    localparam int DATA_W = 64;
    localparam int AW     = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SADR = 3'd3;

    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;

    localparam logic [DATA_W-1:0] LAST_ADDR = DATA_W'(MEM_BYTES - 8);

    // An 8-byte access starting past LAST_ADDR would run off the end of the
    // RAM; the full 64-bit compare also rejects "negative" addresses.
    function automatic logic addr_error(input logic [DATA_W-1:0] addr);
        return addr > LAST_ADDR;
    endfunction

    logic [3:0]        icode_p1;
    logic [2:0]        stat_p1;
    logic [DATA_W-1:0] valE_p1;
    logic [DATA_W-1:0] valA_p1;
    logic [3:0]        dstE_p1;
    logic [3:0]        dstM_p1;
    logic              cnd_p1;

    logic [7:0]        mem [MEM_BYTES];

    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_addr;
    logic              dmem_error;
    logic              wr_en;
    logic [AW-1:0]     base;
    logic [DATA_W-1:0] rd_data;

    // ---- E -> M pipeline register ----
    // M register: reset and bubble insert a NOP, stall holds, otherwise latch E.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || (!memory_stall_i && memory_bubble_i)) begin
            icode_p1 <= INOP;
            stat_p1  <= SAOK;
            valE_p1  <= '0;
            valA_p1  <= '0;
            dstE_p1  <= RNONE;
            dstM_p1  <= RNONE;
            cnd_p1   <= 1'b0;
        end else if (!memory_stall_i) begin
            icode_p1 <= e_icode_i;
            stat_p1  <= e_stat_i;
            valE_p1  <= e_valE_i;
            valA_p1  <= e_valA_i;
            dstE_p1  <= e_dstE_i;
            dstM_p1  <= e_dstM_i;
            cnd_p1   <= e_cnd_i;
        end
    end

    // ---- M stage: address/control decode ----
    // Decode access type and address; popq/ret read through the old stack pointer.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = valE_p1;
        unique case (icode_p1)
            IMRMOVQ:               mem_read  = 1'b1;
            IPOPQ, IRET: begin
                mem_read = 1'b1;
                mem_addr = valA_p1;
            end
            IRMMOVQ, IPUSHQ, ICALL: mem_write = 1'b1;
            default: ;
        endcase
    end

    assign dmem_error = (mem_read || mem_write) && addr_error(mem_addr);
    assign base       = mem_addr[AW-1:0];

    // Stores are blocked while either this instruction or the one in
    // writeback has already faulted, so nothing after an exception commits.
    assign wr_en = rst_n_i && mem_write && !dmem_error &&
                   (stat_p1 == SAOK) && (W_stat_i == SAOK);

    // Asynchronous 8-byte little-endian read at any byte offset.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < 8; k++) begin
            rd_data[8*k +: 8] = mem[base + AW'(k)];
        end
    end

    // Commit a store of valA; RAM has no reset so contents survive rst_n_i.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int k = 0; k < 8; k++) begin
                mem[base + AW'(k)] <= valA_p1[8*k +: 8];
            end
        end
    end

    assign m_valM_o = (mem_read && !dmem_error) ? rd_data : '0;
    assign m_stat_o = dmem_error ? SADR : stat_p1;

    assign M_icode_o = icode_p1;
    assign M_valE_o  = valE_p1;
    assign M_valA_o  = valA_p1;
    assign M_dstE_o  = dstE_p1;
    assign M_dstM_o  = dstM_p1;
    assign M_cnd_o   = cnd_p1;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: reset, store/load, stack addressing,
// unaligned access, address errors, stall/bubble priority and store gating.
module tb_memory_stage;

    localparam int MEM_BYTES = 4096;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        memory_stall_i;
    logic        memory_bubble_i;
    logic [3:0]  e_icode_i;
    logic [2:0]  e_stat_i;
    logic [63:0] e_valE_i;
    logic [63:0] e_valA_i;
    logic [3:0]  e_dstE_i;
    logic [3:0]  e_dstM_i;
    logic        e_cnd_i;
    logic [2:0]  W_stat_i;
    logic [3:0]  M_icode_o;
    logic [63:0] M_valE_o;
    logic [63:0] M_valA_o;
    logic [3:0]  M_dstE_o;
    logic [3:0]  M_dstM_o;
    logic        M_cnd_o;
    logic [63:0] m_valM_o;
    logic [2:0]  m_stat_o;

    int total = 0;
    int bad   = 0;

    memory_stage #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .memory_stall_i  (memory_stall_i),
        .memory_bubble_i (memory_bubble_i),
        .e_icode_i       (e_icode_i),
        .e_stat_i        (e_stat_i),
        .e_valE_i        (e_valE_i),
        .e_valA_i        (e_valA_i),
        .e_dstE_i        (e_dstE_i),
        .e_dstM_i        (e_dstM_i),
        .e_cnd_i         (e_cnd_i),
        .W_stat_i        (W_stat_i),
        .M_icode_o       (M_icode_o),
        .M_valE_o        (M_valE_o),
        .M_valA_o        (M_valA_o),
        .M_dstE_o        (M_dstE_o),
        .M_dstM_o        (M_dstM_o),
        .M_cnd_o         (M_cnd_o),
        .m_valM_o        (m_valM_o),
        .m_stat_o        (m_stat_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Present an E-stage instruction on the inputs.
    task automatic drive(input logic [3:0] icode, input logic [2:0] stat,
                         input logic [63:0] valE, input logic [63:0] valA,
                         input logic [3:0] dstE, input logic [3:0] dstM,
                         input logic cnd);
        e_icode_i = icode;
        e_stat_i  = stat;
        e_valE_i  = valE;
        e_valA_i  = valA;
        e_dstE_i  = dstE;
        e_dstM_i  = dstM;
        e_cnd_i   = cnd;
    endtask

    // Advance one clock; outputs are stable 1 time unit after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_n_i         = 1'b0;
        memory_stall_i  = 1'b0;
        memory_bubble_i = 1'b0;
        W_stat_i        = 3'd1;
        drive(4'h4, 3'd1, 64'h100, 64'h5555, 4'h3, 4'hF, 1'b1);

        // Reset, with a store pending on the inputs.
        step();
        step();
        chk("rst_icode", 64'(M_icode_o), 64'h1);
        chk("rst_dstE",  64'(M_dstE_o),  64'hF);
        chk("rst_dstM",  64'(M_dstM_o),  64'hF);
        chk("rst_valE",  M_valE_o,       64'h0);
        chk("rst_valA",  M_valA_o,       64'h0);
        chk("rst_cnd",   64'(M_cnd_o),   64'h0);
        chk("rst_stat",  64'(m_stat_o),  64'h1);
        chk("rst_valM",  m_valM_o,       64'h0);
        rst_n_i = 1'b1;

        // Store then load at 0x100.
        drive(4'h4, 3'd1, 64'h100, 64'h1122334455667788, 4'hF, 4'hF, 1'b0);
        step();
        chk("st_stat", 64'(m_stat_o), 64'h1);
        chk("st_valM", m_valM_o, 64'h0);
        drive(4'h5, 3'd1, 64'h100, 64'h0, 4'hF, 4'h2, 1'b0);
        step();
        chk("ld_valM", m_valM_o, 64'h1122334455667788);
        chk("ld_dstM", 64'(M_dstM_o), 64'h2);
        drive(4'h5, 3'd1, 64'hFD, 64'h0, 4'hF, 4'h2, 1'b0);
        step();
        chk("byte_100", 64'(m_valM_o[31:24]), 64'h88);

        // Push then pop via the old stack pointer in valA.
        drive(4'hA, 3'd1, 64'h1F8, 64'hAB, 4'h4, 4'hF, 1'b0);
        step();
        drive(4'hB, 3'd1, 64'h200, 64'h1F8, 4'h4, 4'h1, 1'b1);
        step();
        chk("pop_valM", m_valM_o, 64'hAB);
        chk("pop_valE", M_valE_o, 64'h200);
        chk("pop_valA", M_valA_o, 64'h1F8);
        chk("pop_cnd",  64'(M_cnd_o), 64'h1);
        chk("pop_dstE", 64'(M_dstE_o), 64'h4);

        // Unaligned store at 0x103 overlapping the earlier word.
        drive(4'h4, 3'd1, 64'h103, 64'hFFEEDDCCBBAA9988, 4'hF, 4'hF, 1'b0);
        step();
        drive(4'h5, 3'd1, 64'h103, 64'h0, 4'hF, 4'h2, 1'b0);
        step();
        chk("unal_103", m_valM_o, 64'hFFEEDDCCBBAA9988);
        drive(4'h5, 3'd1, 64'h100, 64'h0, 4'hF, 4'h2, 1'b0);
        step();
        chk("unal_100", m_valM_o, 64'hCCBBAA9988667788);

        // Address limits: last legal start, one past it.
        drive(4'h4, 3'd1, 64'(MEM_BYTES - 8), 64'h0123456789ABCDEF, 4'hF, 4'hF, 1'b0);
        step();
        chk("edge_st_stat", 64'(m_stat_o), 64'h1);
        drive(4'h5, 3'd1, 64'(MEM_BYTES - 7), 64'h0, 4'hF, 4'h2, 1'b0);
        step();
        chk("oob_ld_stat", 64'(m_stat_o), 64'h3);
        chk("oob_ld_valM", m_valM_o, 64'h0);
        drive(4'h4, 3'd1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hDEADBEEFDEADBEEF, 4'hF, 4'hF, 1'b0);
        step();
        chk("neg_st_stat", 64'(m_stat_o), 64'h3);
        drive(4'h5, 3'd1, 64'(MEM_BYTES - 8), 64'h0, 4'hF, 4'h2, 1'b0);
        step();
        chk("edge_ld_stat", 64'(m_stat_o), 64'h1);
        chk("neg_st_nowrite", m_valM_o, 64'h0123456789ABCDEF);

        // Stall holds, stall beats bubble, bubble alone inserts a NOP.
        drive(4'h5, 3'd1, 64'h103, 64'h0, 4'hF, 4'h2, 1'b0);
        step();
        memory_stall_i = 1'b1;
        drive(4'h4, 3'd1, 64'h500, 64'h77, 4'h3, 4'hF, 1'b1);
        step();
        chk("stall_icode", 64'(M_icode_o), 64'h5);
        chk("stall_valE",  M_valE_o, 64'h103);
        chk("stall_valM",  m_valM_o, 64'hFFEEDDCCBBAA9988);
        memory_bubble_i = 1'b1;
        step();
        chk("stbub_icode", 64'(M_icode_o), 64'h5);
        chk("stbub_dstM",  64'(M_dstM_o), 64'h2);
        memory_stall_i = 1'b0;
        step();
        chk("bub_icode", 64'(M_icode_o), 64'h1);
        chk("bub_dstE",  64'(M_dstE_o), 64'hF);
        chk("bub_dstM",  64'(M_dstM_o), 64'hF);
        chk("bub_valE",  M_valE_o, 64'h0);
        memory_bubble_i = 1'b0;

        // Store suppressed while W holds a halted instruction.
        W_stat_i = 3'd2;
        drive(4'h4, 3'd1, 64'h100, 64'h0, 4'hF, 4'hF, 1'b0);
        step();
        chk("wgate_stat", 64'(m_stat_o), 64'h1);
        drive(4'h5, 3'd1, 64'h100, 64'h0, 4'hF, 4'h2, 1'b0);
        step();
        W_stat_i = 3'd1;
        chk("wgate_nowrite", m_valM_o, 64'hCCBBAA9988667788);

        // Store suppressed when the instruction itself carries a bad status.
        drive(4'h4, 3'd2, 64'h100, 64'h0, 4'hF, 4'hF, 1'b0);
        step();
        chk("mgate_stat", 64'(m_stat_o), 64'h2);
        drive(4'h5, 3'd1, 64'h100, 64'h0, 4'hF, 4'h2, 1'b0);
        step();
        chk("mgate_nowrite", m_valM_o, 64'hCCBBAA9988667788);

        // A store sitting in M when reset arrives is dropped.
        drive(4'h4, 3'd1, 64'h100, 64'h0, 4'hF, 4'hF, 1'b0);
        step();
        rst_n_i = 1'b0;
        drive(4'h5, 3'd1, 64'h100, 64'h0, 4'hF, 4'h2, 1'b0);
        step();
        rst_n_i = 1'b1;
        step();
        chk("rst_drop", m_valM_o, 64'hCCBBAA9988667788);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Y86-64 pipeline M stage: the downstream consumer of the execute stage's valE/dstE/cnd/stat outputs.
- Holds the E→M pipeline register and performs data-memory access for rmmovq, mrmovq, pushq, popq, call and ret against an internal byte-addressed data RAM.
- Produces valM and the M-stage status consumed by writeback and the hazard/forwarding logic.

Parameters:
- MEM_BYTES, 4096, data RAM size in bytes; must be ≥ 8.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset; one clock; reset is synchronous and active-low
- memory_stall_i  in  1  hold M pipeline register
- memory_bubble_i  in  1  load NOP bubble into M register
- e_icode_i  in  4  icode from execute
- e_stat_i  in  3  status from execute
- e_valE_i  in  64  ALU result from execute
- e_valA_i  in  64  valA passed through execute
- e_dstE_i  in  4  dstE from execute (already RNONE for a not-taken cmov)
- e_dstM_i  in  4  dstM from execute
- e_cnd_i  in  1  condition from execute
- W_stat_i  in  3  status of instruction currently in W
- M_icode_o  out  4  registered icode
- M_valE_o  out  64  registered valE
- M_valA_o  out  64  registered valA (jump-mispredict path)
- M_dstE_o  out  4  registered dstE
- M_dstM_o  out  4  registered dstM
- M_cnd_o  out  1  registered cnd
- m_valM_o  out  64  loaded data (combinational)
- m_stat_o  out  3  M-stage status (combinational)

Behaviour:
- Encodings:
  - Status: SAOK=1, SHLT=2, SADR=3, SINS=4.
  - icodes: INOP=1, IRMMOVQ=4, IMRMOVQ=5, ICALL=8, IRET=9, IPUSHQ=A, IPOPQ=B.
  - RNONE=F.
- M register update, posedge clk_i, priority order:
  - Reset (rst_n_i=0): icode=INOP, stat=SAOK, valE=valA=0, dstE=dstM=RNONE, cnd=0.
  - Else if memory_stall_i: hold all fields. Stall beats bubble.
  - Else if memory_bubble_i: load the same values as reset.
  - Else: latch the e_* inputs.
- Internal M_stat holds the latched e_stat_i.
- Address selection: mem_addr = M_valE for rmmovq, pushq, call, mrmovq; mem_addr = M_valA for popq and ret.
- Access type:
  - mem_read for mrmovq, popq, ret.
  - mem_write for rmmovq, pushq, call; write data = M_valA.
- Address error (dmem_error): mem_read or mem_write active and unsigned mem_addr > MEM_BYTES-8. Full 64-bit compare, so negative addresses are errors.
- RAM access width: 8 bytes, little-endian, any byte alignment (unaligned allowed). Byte k of the word is at mem_addr+k.
- Read is asynchronous:
  - m_valM_o = assembled 8 bytes when mem_read and no dmem_error.
  - Otherwise m_valM_o = 0.
- Write occurs at posedge when all of the following hold:
  - rst_n_i=1 and mem_write
  - no dmem_error
  - M_stat==SAOK
  - W_stat_i==SAOK
- Write is otherwise suppressed. A write repeated while stalled is idempotent and permitted.
- m_stat_o = SADR if dmem_error, else M_stat.
- Ordering: a store in cycle N is visible to a load in cycle N+1. Only one access per cycle, so there is no intra-cycle conflict.
- RAM contents are not cleared by reset. A store coinciding with a reset edge is dropped.
- Latency:
  - M register: 1 cycle.
  - valM and m_stat: combinational from the M register plus RAM.

Test Plan:
- Reset: hold rst_n_i=0 for 2 cycles → M_icode_o=1, M_dstE_o=M_dstM_o=F, M_valE_o=0, m_stat_o=1, m_valM_o=0.
- Store/load: rmmovq (icode 4), valE=0x100, valA=0x1122334455667788; next cycle mrmovq, valE=0x100 → m_valM_o=0x1122334455667788. Byte at 0x100 = 0x88.
- Push/pop addressing: pushq, valE=0x1F8, valA=0xAB; then popq, valA=0x1F8, valE=0x200 → m_valM_o=0xAB, M_valE_o=0x200.
- Unaligned access: write 0xFFEEDDCCBBAA9988 at 0x103; read at 0x103 → same value. Read at 0x100 → low 3 bytes unchanged, byte 3 = 0x88.
- Address error: mrmovq with valE=MEM_BYTES-7 → m_stat_o=3, m_valM_o=0. rmmovq to 0xFFFF_FFFF_FFFF_FFF8 → m_stat_o=3, and no RAM byte changes.
- Stall/bubble/W gating:
  - stall=1 with new e_* inputs → M outputs unchanged.
  - stall=1 and bubble=1 → hold.
  - bubble=1 alone → NOP with dst=F.
  - rmmovq with W_stat_i=2 → RAM unchanged, m_stat_o=1.
